// File: rtl/airi5c_round_pack.sv
// Two-stage round-and-pack for the FPU: S1 picks the rounding increment and adds it,
// S2 fixes up carry/subnormal promotion, detects overflow, applies specials and packs the IEEE word.
module airi5c_round_pack #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic               i_clk,
  input  logic               i_n_reset,
  input  logic               i_flush,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [2:0]         i_rm,
  input  logic               i_sgn,
  input  logic [EXP_W:0]     i_exp_in,
  input  logic [MAN_W:0]     i_man_in,
  input  logic               i_round_bit,
  input  logic               i_sticky_bit,
  input  logic               i_is_nan,
  input  logic               i_is_inf,
  input  logic               i_nv_in,
  input  logic               i_dz_in,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [EXP_W+MAN_W:0] o_result,
  output logic [4:0]         o_fflags,
  output logic               o_rm_invalid
);

  localparam int unsigned W     = EXP_W + MAN_W + 1;
  localparam int unsigned SUM_W = MAN_W + 2;
  localparam int unsigned EW2   = EXP_W + 2;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [EW2-1:0]   EXP_OVF  = EW2'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MAN_W-1:0] FRAC_ONES = '1;
  localparam logic [MAN_W-1:0] FRAC_ZERO = '0;
  localparam logic [MAN_W-1:0] FRAC_QNAN = {1'b1, {(MAN_W-1){1'b0}}};

  logic                 w_s1_adv, w_s2_adv;
  logic                 w_inc, w_rm_inv;
  logic [SUM_W-1:0]     w_sum;

  logic                 r_s1_v, r_s1_c, r_s1_sgn, r_s1_nan, r_s1_inf;
  logic                 r_s1_nv, r_s1_dz, r_s1_nx, r_s1_rmi;
  logic [2:0]           r_s1_rm;
  logic [MAN_W:0]       r_s1_m;
  logic [EXP_W:0]       r_s1_exp;

  logic [EW2-1:0]       w_exp_fix;
  logic [MAN_W:0]       w_sig;
  logic                 w_ovf, w_ovf_inf;
  logic [W-1:0]         w_result;
  logic [4:0]           w_fflags;

  logic                 r_s2_v, r_rm_invalid;
  logic [W-1:0]         r_result;
  logic [4:0]           r_fflags;

  // Elastic handshake: a stage advances when it is empty or its consumer takes its entry.
  assign w_s2_adv   = !r_s2_v || i_out_ready;
  assign w_s1_adv   = !r_s1_v || w_s2_adv;
  assign o_in_ready = w_s1_adv;

  always_comb begin
    w_inc    = 1'b0;
    w_rm_inv = 1'b0;
    case (i_rm)
      RM_RNE:  w_inc = i_round_bit && (i_sticky_bit || i_man_in[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = (i_round_bit || i_sticky_bit) && i_sgn;
      RM_RUP:  w_inc = (i_round_bit || i_sticky_bit) && !i_sgn;
      RM_RMM:  w_inc = i_round_bit;
      default: w_rm_inv = 1'b1;
    endcase
  end

  assign w_sum = {1'b0, i_man_in} + SUM_W'(w_inc);

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_s1_v   <= 1'b0;
      r_s1_c   <= 1'b0;
      r_s1_m   <= '0;
      r_s1_exp <= '0;
      r_s1_sgn <= 1'b0;
      r_s1_rm  <= '0;
      r_s1_nan <= 1'b0;
      r_s1_inf <= 1'b0;
      r_s1_nv  <= 1'b0;
      r_s1_dz  <= 1'b0;
      r_s1_nx  <= 1'b0;
      r_s1_rmi <= 1'b0;
    end else begin
      if (i_flush)       r_s1_v <= 1'b0;
      else if (w_s1_adv) r_s1_v <= i_in_valid;
      if (w_s1_adv && i_in_valid) begin
        r_s1_c   <= w_sum[SUM_W-1];
        r_s1_m   <= w_sum[MAN_W:0];
        r_s1_exp <= i_exp_in;
        r_s1_sgn <= i_sgn;
        r_s1_rm  <= i_rm;
        r_s1_nan <= i_is_nan;
        r_s1_inf <= i_is_inf;
        r_s1_nv  <= i_nv_in;
        r_s1_dz  <= i_dz_in;
        r_s1_nx  <= i_round_bit || i_sticky_bit;
        r_s1_rmi <= w_rm_inv;
      end
    end
  end

  // Carry renormalises to 1.0 at exp+1; a subnormal whose hidden bit became 1 moves to exp 1.
  always_comb begin
    w_sig = r_s1_c ? {1'b1, FRAC_ZERO} : r_s1_m;
    if (r_s1_c)                                  w_exp_fix = EW2'(r_s1_exp) + EW2'(1);
    else if (r_s1_exp == '0 && r_s1_m[MAN_W])    w_exp_fix = EW2'(1);
    else                                         w_exp_fix = EW2'(r_s1_exp);
    w_ovf     = (w_exp_fix >= EXP_OVF);
    w_ovf_inf = (r_s1_rm == RM_RNE) || (r_s1_rm == RM_RMM) ||
                (r_s1_rm == RM_RUP && !r_s1_sgn) || (r_s1_rm == RM_RDN && r_s1_sgn);
    w_result  = {r_s1_sgn, w_exp_fix[EXP_W-1:0], w_sig[MAN_W-1:0]};
    w_fflags  = {r_s1_nv, r_s1_dz, 1'b0, r_s1_nx && !w_sig[MAN_W], r_s1_nx};
    if (r_s1_nan) begin
      w_result = {1'b0, EXP_ONES, FRAC_QNAN};
      w_fflags = {r_s1_nv, 4'b0000};
    end else if (r_s1_inf) begin
      w_result = {r_s1_sgn, EXP_ONES, FRAC_ZERO};
      w_fflags = {r_s1_nv, r_s1_dz, 3'b000};
    end else if (w_ovf) begin
      w_result = w_ovf_inf ? {r_s1_sgn, EXP_ONES, FRAC_ZERO} : {r_s1_sgn, EXP_MAXF, FRAC_ONES};
      w_fflags = {r_s1_nv, r_s1_dz, 1'b1, 1'b0, 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_s2_v       <= 1'b0;
      r_result     <= '0;
      r_fflags     <= '0;
      r_rm_invalid <= 1'b0;
    end else begin
      if (i_flush)       r_s2_v <= 1'b0;
      else if (w_s2_adv) r_s2_v <= r_s1_v;
      if (w_s2_adv && r_s1_v) begin
        r_result     <= w_result;
        r_fflags     <= w_fflags;
        r_rm_invalid <= r_s1_rmi;
      end
    end
  end

  assign o_out_valid  = r_s2_v;
  assign o_result     = r_result;
  assign o_fflags     = r_fflags;
  assign o_rm_invalid = r_rm_invalid;

endmodule

// File: tb/tb_airi5c_round_pack.sv
// Directed bench for airi5c_round_pack (binary32): rounding modes, carry, overflow, subnormals,
// specials, latency, backpressure ordering, flush and asynchronous reset.
module tb_airi5c_round_pack;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  typedef struct {
    string       tag;
    logic [2:0]  rm;
    logic        sgn;
    logic [8:0]  e;
    logic [23:0] m;
    logic        r, s, nan, inf, nv, dz;
    logic [31:0] res;
    logic [4:0]  ff;
    logic        rmi;
  } vec_t;

  logic        clk = 1'b0;
  logic        i_n_reset, i_flush, i_in_valid, o_in_ready;
  logic [2:0]  i_rm;
  logic        i_sgn;
  logic [8:0]  i_exp_in;
  logic [23:0] i_man_in;
  logic        i_round_bit, i_sticky_bit, i_is_nan, i_is_inf, i_nv_in, i_dz_in;
  logic        o_out_valid, i_out_ready;
  logic [31:0] o_result;
  logic [4:0]  o_fflags;
  logic        o_rm_invalid;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t exp_q[$];
  vec_t vt[$];
  vec_t mon_e;

  always #5 clk = ~clk;

  airi5c_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .i_clk(clk), .i_n_reset(i_n_reset), .i_flush(i_flush),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_rm(i_rm), .i_sgn(i_sgn), .i_exp_in(i_exp_in), .i_man_in(i_man_in),
    .i_round_bit(i_round_bit), .i_sticky_bit(i_sticky_bit),
    .i_is_nan(i_is_nan), .i_is_inf(i_is_inf), .i_nv_in(i_nv_in), .i_dz_in(i_dz_in),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_result(o_result), .o_fflags(o_fflags), .o_rm_invalid(o_rm_invalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic vec_t mk(input string tag, input int rm, input int sgn, input int e,
                              input int m, input int r, input int s, input int res, input int ff);
    vec_t v;
    v.tag = tag;   v.rm = 3'(rm);  v.sgn = 1'(sgn); v.e = 9'(e); v.m = 24'(m);
    v.r = 1'(r);   v.s = 1'(s);    v.nan = 1'b0;    v.inf = 1'b0; v.nv = 1'b0; v.dz = 1'b0;
    v.res = 32'(res); v.ff = 5'(ff); v.rmi = 1'b0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    i_rm = v.rm; i_sgn = v.sgn; i_exp_in = v.e; i_man_in = v.m;
    i_round_bit = v.r; i_sticky_bit = v.s; i_is_nan = v.nan; i_is_inf = v.inf;
    i_nv_in = v.nv; i_dz_in = v.dz;
  endtask

  // Presents one beat, holds it until accepted, returns just after the accepting edge.
  task automatic send(input vec_t v, input bit track);
    bit ok = 1'b0;
    apply(v);
    i_in_valid = 1'b1;
    if (track) exp_q.push_back(v);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check({v.tag, "_accept_timeout"}, 32'(0), 32'(1));
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(exp_q.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  // Scoreboard: every transferred result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (i_n_reset && o_out_valid && i_out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", o_result, 32'hDEAD_BEEF);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.tag, "_res"}, o_result, mon_e.res);
        check({mon_e.tag, "_ff"},  32'(o_fflags), 32'(mon_e.ff));
        check({mon_e.tag, "_rmi"}, 32'(o_rm_invalid), 32'(mon_e.rmi));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t bp[4];
    int   cnt;
    i_n_reset = 1'b0; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
    apply(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0));

    vt.push_back(mk("tie_rne",     0, 0, 127, 'h800000, 1, 0, 'h3F800000, 'h01));
    vt.push_back(mk("tie_rmm",     4, 0, 127, 'h800000, 1, 0, 'h3F800001, 'h01));
    vt.push_back(mk("rne_odd",     0, 0, 127, 'h800001, 1, 0, 'h3F800002, 'h01));
    vt.push_back(mk("rne_stk",     0, 0, 127, 'h800000, 0, 1, 'h3F800000, 'h01));
    vt.push_back(mk("exact",       0, 0, 127, 'h800000, 0, 0, 'h3F800000, 'h00));
    vt.push_back(mk("carry",       0, 0, 127, 'hFFFFFF, 1, 1, 'h40000000, 'h01));
    vt.push_back(mk("ovf_rne",     0, 0, 254, 'hFFFFFF, 1, 1, 'h7F800000, 'h05));
    vt.push_back(mk("rtz_top",     1, 0, 254, 'hFFFFFF, 1, 1, 'h7F7FFFFF, 'h01));
    vt.push_back(mk("ovf_rtz",     1, 0, 255, 'h800000, 0, 0, 'h7F7FFFFF, 'h05));
    vt.push_back(mk("ovf_rdn_neg", 2, 1, 254, 'hFFFFFF, 1, 1, 'hFF800000, 'h05));
    vt.push_back(mk("ovf_rup_neg", 3, 1, 255, 'h800000, 0, 0, 'hFF7FFFFF, 'h05));
    vt.push_back(mk("rdn_pos",     2, 0, 127, 'h800000, 1, 0, 'h3F800000, 'h01));
    vt.push_back(mk("rdn_neg",     2, 1, 127, 'h800000, 1, 0, 'hBF800001, 'h01));
    vt.push_back(mk("rup_pos",     3, 0, 127, 'h800000, 0, 1, 'h3F800001, 'h01));
    vt.push_back(mk("sub_rup",     3, 0, 0,   'h7FFFFF, 1, 1, 'h00800000, 'h01));
    vt.push_back(mk("sub_rtz",     1, 0, 0,   'h7FFFFF, 1, 1, 'h007FFFFF, 'h03));
    vt.push_back(mk("sub_tiny",    0, 0, 0,   'h000001, 1, 0, 'h00000002, 'h03));
    vt.push_back(mk("zero_neg",    0, 1, 0,   'h000000, 0, 0, 'h80000000, 'h00));
    v = mk("rm_inv", 5, 0, 127, 'h800000, 1, 1, 'h3F800000, 'h01); v.rmi = 1'b1; vt.push_back(v);
    v = mk("nan", 0, 1, 127, 'h800000, 0, 0, 'h7FC00000, 'h10);
    v.nan = 1'b1; v.inf = 1'b1; v.nv = 1'b1; v.dz = 1'b1; vt.push_back(v);
    v = mk("inf", 0, 1, 127, 'h800000, 1, 1, 'hFF800000, 'h08);
    v.inf = 1'b1; v.dz = 1'b1; vt.push_back(v);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid",    32'(o_out_valid), 32'(0));
    check("rst_result",   o_result,         32'(0));
    check("rst_fflags",   32'(o_fflags),    32'(0));
    check("rst_rminv",    32'(o_rm_invalid), 32'(0));
    check("rst_in_ready", 32'(o_in_ready),  32'(1));
    @(posedge clk); #1;
    i_n_reset = 1'b1;
    @(posedge clk); #1;

    // Latency from an idle pipe
    send(vt[0], 1'b1);
    @(negedge clk); check("lat_c1_valid", 32'(o_out_valid), 32'(0));
    @(negedge clk); check("lat_c2_valid", 32'(o_out_valid), 32'(1));
    drain();

    // Back-to-back directed vectors
    foreach (vt[i]) send(vt[i], 1'b1);
    drain();

    // Backpressure: four beats with the consumer stalled
    for (int k = 0; k < 4; k++)
      bp[k] = mk($sformatf("bp%0d", k), 0, 0, 127, 'h800000 + k, 0, 0, 'h3F800000 + k, 'h00);
    i_out_ready = 1'b0;
    send(bp[0], 1'b1);
    send(bp[1], 1'b1);
    fork
      begin
        send(bp[2], 1'b1);
        send(bp[3], 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("bp_in_ready", 32'(o_in_ready), 32'(0));
          check("bp_hold",     o_result,        bp[0].res);
        end
        @(posedge clk); #1;
        i_out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two beats in flight, then a flush colliding with a new beat
    i_out_ready = 1'b0;
    send(mk("fl0", 0, 0, 127, 'h800000, 0, 0, 0, 0), 1'b0);
    send(mk("fl1", 0, 0, 128, 'h800000, 0, 0, 0, 0), 1'b0);
    @(negedge clk); check("fl_pre_valid", 32'(o_out_valid), 32'(1));
    @(posedge clk); #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b1;
    apply(mk("fl2", 0, 0, 129, 'h800000, 0, 0, 0, 0));
    i_in_valid = 1'b1;
    @(negedge clk); check("fl_coll_ready", 32'(o_in_ready), 32'(1));
    @(posedge clk); #1;
    i_flush = 1'b0; i_in_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_out_valid) cnt++;
    end
    check("fl_no_valid", 32'(cnt), 32'(0));
    @(posedge clk); #1;

    // Asynchronous reset mid-stream
    i_out_ready = 1'b0;
    send(mk("rs0", 0, 0, 127, 'h800000, 0, 0, 0, 0), 1'b0);
    send(mk("rs1", 0, 0, 128, 'h800000, 0, 0, 0, 0), 1'b0);
    @(negedge clk);
    check("rs_pre_result", o_result, 32'h3F800000);
    #2 i_n_reset = 1'b0;
    #1;
    check("rs_async_valid",  32'(o_out_valid), 32'(0));
    check("rs_async_result", o_result,         32'(0));
    check("rs_async_fflags", 32'(o_fflags),    32'(0));
    @(posedge clk); #1;
    i_n_reset = 1'b1;
    i_out_ready = 1'b1;
    @(negedge clk);
    check("rs_post_ready", 32'(o_in_ready),  32'(1));
    check("rs_post_valid", 32'(o_out_valid), 32'(0));
    @(posedge clk); #1;
    send(vt[5], 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
